// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 board sequencer:
// board geometry, tile encoding and the controller state encoding.
package connect4_pkg;

   localparam int ROWS  = 6;
   localparam int COLS  = 7;
   localparam int CELLS = ROWS * COLS;

   typedef logic [1:0] tile_t;

   localparam tile_t EMPTY = 2'b00;
   localparam tile_t P1    = 2'b01;
   localparam tile_t P2    = 2'b10;

   // Row 0 is the top of the board, as the screen drawer expects.
   typedef tile_t [0:ROWS-1][0:COLS-1] board_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FALL,
      ST_LAND,
      ST_FULL
   } state_t;

   function automatic tile_t other_player(input tile_t p);
      return (p == P1) ? P2 : P1;
   endfunction

endpackage

// File: rtl/fall_timer.sv
// Row-step pacing for the falling token: a down-counter that fires a
// one-cycle tick every FALL_TICKS cycles, realigned by restart.
module fall_timer #(
   parameter int unsigned FALL_TICKS = 1250000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(FALL_TICKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      if (restart || (cnt_q == '0)) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // A restart edge begins a fresh period, so it never counts as a tick.
   assign tick = (cnt_q == '0) && !restart;

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/board_controller.sv
// Connect-4 game-state sequencer: owns the tile register, the column
// cursor, turn alternation and the row-by-row token-drop animation.
module board_controller
   import connect4_pkg::*;
#(
   parameter int unsigned FALL_TICKS = 1250000,
   parameter int unsigned START_COL  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_drop,
   output board_t     tiles,
   output logic [2:0] cursor_col,
   output logic [1:0] current_player,
   output logic       busy,
   output logic       drop_done,
   output logic       illegal,
   output logic       board_full
);

   state_t     state_q, state_d;
   board_t     tiles_q, tiles_d;
   logic [2:0] cursor_q, cursor_d;
   logic [2:0] col_q, col_d;
   logic [2:0] row_q, row_d;
   tile_t      player_q, player_d;
   logic [5:0] count_q, count_d;
   logic       busy_q, busy_d;
   logic       drop_done_q, drop_done_d;
   logic       illegal_q, illegal_d;
   logic       full_q, full_d;

   logic       tick;
   logic       restart;
   logic [2:0] row_below;
   logic       below_free;

   fall_timer #(
      .FALL_TICKS (FALL_TICKS)
   ) u_fall_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   assign row_below  = row_q + 3'd1;
   assign below_free = (row_q < 3'(ROWS - 1)) && (tiles_q[row_below][col_q] == EMPTY);

   always_comb begin
      // NOTE: every variable gets a default here so no path infers a latch.
      state_d     = state_q;
      tiles_d     = tiles_q;
      cursor_d    = cursor_q;
      col_d       = col_q;
      row_d       = row_q;
      player_d    = player_q;
      count_d     = count_q;
      busy_d      = busy_q;
      drop_done_d = 1'b0;
      illegal_d   = 1'b0;
      full_d      = full_q;
      restart     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (btn_drop) begin
               if (tiles_q[0][cursor_q] != EMPTY) begin
                  illegal_d = 1'b1;
               end else begin
                  col_d                = cursor_q;
                  row_d                = 3'd0;
                  tiles_d[0][cursor_q] = player_q;
                  busy_d               = 1'b1;
                  restart              = 1'b1;
                  state_d              = ST_FALL;
               end
            end else if (btn_left && !btn_right) begin
               cursor_d = (cursor_q == 3'd0) ? 3'(COLS - 1) : cursor_q - 3'd1;
            end else if (btn_right && !btn_left) begin
               cursor_d = (cursor_q == 3'(COLS - 1)) ? 3'd0 : cursor_q + 3'd1;
            end
         end

         ST_FALL: begin
            if (tick) begin
               if (below_free) begin
                  tiles_d[row_q][col_q]     = EMPTY;
                  tiles_d[row_below][col_q] = player_q;
                  row_d                     = row_below;
               end else begin
                  drop_done_d = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = ST_LAND;
               end
            end
         end

         ST_LAND: begin
            count_d  = (count_q == 6'(CELLS)) ? count_q : count_q + 6'd1;
            player_d = other_player(player_q);
            if (count_q + 6'd1 == 6'(CELLS)) begin
               full_d  = 1'b1;
               state_d = ST_FULL;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_FULL: begin
            state_d = ST_FULL;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tiles_q     <= '0;
         cursor_q    <= 3'(START_COL);
         col_q       <= 3'd0;
         row_q       <= 3'd0;
         player_q    <= P1;
         count_q     <= 6'd0;
         busy_q      <= 1'b0;
         drop_done_q <= 1'b0;
         illegal_q   <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tiles_q     <= tiles_d;
         cursor_q    <= cursor_d;
         col_q       <= col_d;
         row_q       <= row_d;
         player_q    <= player_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         drop_done_q <= drop_done_d;
         illegal_q   <= illegal_d;
         full_q      <= full_d;
      end
   end

   assign tiles          = tiles_q;
   assign cursor_col     = cursor_q;
   assign current_player = player_q;
   assign busy           = busy_q;
   assign drop_done      = drop_done_q;
   assign illegal        = illegal_q;
   assign board_full     = full_q;

endmodule
